// File: rtl/cart_sav_engine.sv
// cart_sav_engine
//
// Backup engine that copies cartridge save RAM to and from the SD-card block
// interface in 512-byte blocks. It drives the otherwise unused port B of the
// cart RAM, which is 16 bits wide: the low byte comes from the low bank and the
// high byte from the high bank, and both banks share one word address.
//   Load : SD -> cart RAM (run after a save image is mounted)
//   Save : cart RAM -> SD (run on user request)
//
// Optional build macro:
//   CART_SAV_TIMEOUT_EN - bounds the wait for sd_ack in REQ to ACK_TIMEOUT
//                         cycles and raises the sticky sav_err flag when the
//                         bound expires. Without it, REQ waits indefinitely
//                         and sav_err is tied low.
//
// Ports:
//   clk_sys, reset             system clock; synchronous active-high reset
//   cart_mbc_type              cartridge header byte 0x147
//   cart_ram_size              cartridge header byte 0x149
//   sav_load, sav_save         single-cycle start pulses (load wins if both)
//   sav_supported              cartridge has battery-backed RAM
//   busy, done, sav_err        transfer in progress / completion pulse / timeout
//   sd_lba, sd_rd, sd_wr       block number and block read/write requests
//   sd_ack                     SD side owns the buffer while high
//   sd_buff_addr               16-bit word index inside the current block
//   sd_buff_dout, sd_buff_wr   load data from SD and its strobe
//   sd_buff_din                save data to SD (cart RAM read data)
//   ram_addr, ram_wren,
//   ram_din, ram_q             cart RAM port B; ram_q lags ram_addr by 1 clk
module cart_sav_engine #(
    parameter int LBA_W       = 8,
    parameter int ACK_TIMEOUT = 1048575
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  cart_mbc_type,
    input  logic [7:0]  cart_ram_size,
    input  logic        sav_load,
    input  logic        sav_save,
    output logic        sav_supported,
    output logic        busy,
    output logic        done,
    output logic        sav_err,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic [15:0] sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [15:0] sd_buff_din,
    output logic [15:0] ram_addr,
    output logic        ram_wren,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_q
);

    localparam logic [19:0] TIMEOUT_LIM = 20'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [LBA_W-1:0]   blk_q;
    logic               dir_save_q;
    logic               sd_rd_q;
    logic               sd_wr_q;
    logic               done_q;
    logic               busy_q;
    logic               ram_wren_q;
    logic [15:0]        ram_din_q;
    logic [15:0]        ram_addr_q;

    logic               is_batt;
    logic               is_mbc2;
    logic [LBA_W-1:0]   last_blk;
    logic               start_accept;
    logic               in_xfer;
    logic               timeout_hit;
    logic [15:0]        word_addr_d;

    // Port-B word address: block number in the upper bits, word index below.
    function automatic logic [15:0] word_addr(input logic [LBA_W-1:0] b,
                                              input logic [7:0]       a);
        return 16'({b, a});
    endfunction

    // Header decode
    always_comb begin
        is_batt = 1'b0;
        case (cart_mbc_type)
            8'h03, 8'h06, 8'h09, 8'h0D, 8'h10,
            8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF: is_batt = 1'b1;
            default:                           is_batt = 1'b0;
        endcase
        is_mbc2       = (cart_mbc_type == 8'h05) || (cart_mbc_type == 8'h06);
        sav_supported = is_batt && ((cart_ram_size != 8'h00) || is_mbc2);

        // MBC2 keeps 512 x 4-bit internally, which fits in a single block.
        if (is_mbc2) begin
            last_blk = '0;
        end else begin
            case (cart_ram_size)
                8'h01:   last_blk = LBA_W'(3);
                8'h02:   last_blk = LBA_W'(15);
                8'h03:   last_blk = LBA_W'(63);
                default: last_blk = LBA_W'(255);
            endcase
        end
    end

    assign start_accept = (state_q == S_IDLE) && sav_supported && (sav_load || sav_save);
    assign in_xfer      = (state_q == S_REQ) || (state_q == S_XFER);
    assign word_addr_d  = word_addr(blk_q, sd_buff_addr);

`ifdef CART_SAV_TIMEOUT_EN
    logic [19:0] cnt_q;
    logic        err_q;

    assign timeout_hit = (cnt_q == TIMEOUT_LIM);
    assign sav_err     = err_q;

    // Counter sits at zero outside REQ, so every entry into REQ starts fresh.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_REQ) begin
                cnt_q <= cnt_q + 20'd1;
            end else begin
                cnt_q <= '0;
            end

            if (start_accept) begin
                err_q <= 1'b0;
            end else if ((state_q == S_REQ) && !sd_ack && timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_LIM;
    assign timeout_hit        = 1'b0;
    assign sav_err            = 1'b0;
`endif

    // Control FSM and port-B datapath registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            dir_save_q <= 1'b0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ram_wren_q <= 1'b0;
            ram_din_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            ram_wren_q <= 1'b0;

            // Load: each SD buffer write becomes exactly one RAM write on the
            // following cycle. Save: track the live address so ram_addr holds
            // its last value once the transfer ends.
            if (in_xfer && !dir_save_q && sd_ack && sd_buff_wr) begin
                ram_wren_q <= 1'b1;
                ram_addr_q <= word_addr_d;
                ram_din_q  <= sd_buff_dout;
            end else if (in_xfer && dir_save_q) begin
                ram_addr_q <= word_addr_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_accept) begin
                        dir_save_q <= !sav_load;
                        blk_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end

                // Request strobe rises one cycle after entering REQ.
                S_REQ: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= S_XFER;
                    end else if (timeout_hit) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        sd_rd_q <= !dir_save_q;
                        sd_wr_q <= dir_save_q;
                    end
                end

                // Entry into XFER follows a cycle with sd_ack high, so a low
                // sd_ack here is the falling edge that closes the block.
                S_XFER: begin
                    if (!sd_ack) begin
                        if (blk_q >= last_blk) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            blk_q   <= blk_q + 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_lba      = 32'(blk_q);
    assign ram_wren    = ram_wren_q;
    assign ram_din     = ram_din_q;
    assign sd_buff_din = ram_q;
    // During a save the RAM follows sd_buff_addr directly so ram_q lands one
    // clock after the SD side changes the word index.
    assign ram_addr    = (dir_save_q && in_xfer) ? word_addr_d : ram_addr_q;

endmodule

// File: tb/tb_cart_sav_engine.sv
module tb_cart_sav_engine;

    localparam int TB_TIMEOUT = 64;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [7:0]  cart_mbc_type;
    logic [7:0]  cart_ram_size;
    logic        sav_load;
    logic        sav_save;
    logic        sav_supported;
    logic        busy;
    logic        done;
    logic        sav_err;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic [15:0] ram_addr;
    logic        ram_wren;
    logic [15:0] ram_din;
    logic [15:0] ram_q;

    cart_sav_engine #(
        .LBA_W       (8),
        .ACK_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .cart_mbc_type (cart_mbc_type),
        .cart_ram_size (cart_ram_size),
        .sav_load      (sav_load),
        .sav_save      (sav_save),
        .sav_supported (sav_supported),
        .busy          (busy),
        .done          (done),
        .sav_err       (sav_err),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_dout  (sd_buff_dout),
        .sd_buff_wr    (sd_buff_wr),
        .sd_buff_din   (sd_buff_din),
        .ram_addr      (ram_addr),
        .ram_wren      (ram_wren),
        .ram_din       (ram_din),
        .ram_q         (ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    // Cart RAM model for port B: content is a fixed scramble of the address.
    function automatic logic [15:0] ram_img(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    always @(posedge clk_sys) ram_q <= ram_img(ram_addr);

    int checks   = 0;
    int errors   = 0;
    int wren_cnt = 0;
    int wren_bad = 0;
    int done_cnt = 0;
    int wr_cyc   = 0;

    always @(negedge clk_sys) begin
        if (ram_wren === 1'b1) begin
            wren_cnt++;
            if (ram_addr !== ram_din) wren_bad++;
        end
        if (done === 1'b1)  done_cnt++;
        if (sd_wr === 1'b1) wr_cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic pulse(input logic l, input logic s);
        sav_load = l;
        sav_save = s;
        tick();
        sav_load = 1'b0;
        sav_save = 1'b0;
    endtask

    task automatic wait_req(input bit is_load, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((is_load ? sd_rd : sd_wr) === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // One SD block: wait for the request, own the buffer, move nwords words.
    task automatic do_block(input bit is_load, input int blk, input int nwords);
        bit         ok;
        int         bad;
        logic [7:0] b8;
        logic [7:0] a8;
        bad = 0;
        b8  = 8'(blk);
        wait_req(is_load, ok);
        check("req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        check("sd_lba", sd_lba, 32'(blk));
        check("other_strobe", 32'(is_load ? sd_wr : sd_rd), 32'd0);
        sd_ack       = 1'b1;
        sd_buff_addr = 8'd0;
        tick();
        check("strobe_drop", 32'(sd_rd | sd_wr), 32'd0);
        for (int a = 0; a < nwords; a++) begin
            a8           = 8'(a);
            sd_buff_addr = a8;
            if (is_load) begin
                sd_buff_dout = {b8, a8};
                sd_buff_wr   = 1'b1;
                tick();
            end else begin
                tick();
                if (sd_buff_din !== ram_img({b8, a8})) bad++;
                if (ram_wren !== 1'b0) bad++;
            end
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        if (!is_load) check("save_data_bad", 32'(bad), 32'd0);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_xfer(input bit is_load, input int first, input int last_ex,
                            input int nwords, input bit expect_done);
        for (int b = first; b < last_ex; b++) do_block(is_load, b, nwords);
        if (expect_done) wait_done();
    endtask

    typedef struct {
        logic [7:0] mbc;
        logic [7:0] rsz;
        bit         sup;
        int         nblk;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int d0, w0, b0, c0, bad;
        bit ok;

        vecs[0]  = '{8'h03, 8'h02, 1'b1, 16};
        vecs[1]  = '{8'h03, 8'h00, 1'b0, 0};
        vecs[2]  = '{8'h06, 8'h00, 1'b1, 1};
        vecs[3]  = '{8'h05, 8'h00, 1'b0, 0};
        vecs[4]  = '{8'h13, 8'h01, 1'b1, 4};
        vecs[5]  = '{8'h1B, 8'h03, 1'b1, 64};
        vecs[6]  = '{8'h1E, 8'h04, 1'b1, 256};
        vecs[7]  = '{8'hFF, 8'h05, 1'b1, 256};
        vecs[8]  = '{8'h01, 8'h02, 1'b0, 0};
        vecs[9]  = '{8'h10, 8'h02, 1'b1, 16};
        vecs[10] = '{8'h22, 8'h03, 1'b1, 64};
        vecs[11] = '{8'h0F, 8'h02, 1'b0, 0};

        reset         = 1'b1;
        cart_mbc_type = 8'h00;
        cart_ram_size = 8'h00;
        sav_load      = 1'b0;
        sav_save      = 1'b0;
        sd_ack        = 1'b0;
        sd_buff_addr  = 8'd0;
        sd_buff_dout  = 16'd0;
        sd_buff_wr    = 1'b0;
        repeat (3) tick();
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_sav_err", 32'(sav_err), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        reset = 1'b0;
        tick();

        // Decode table, with a short save run for every supported entry.
        for (int v = 0; v < 12; v++) begin
            cart_mbc_type = vecs[v].mbc;
            cart_ram_size = vecs[v].rsz;
            tick();
            check("sav_supported", 32'(sav_supported), 32'(vecs[v].sup));
            d0 = done_cnt;
            w0 = wren_cnt;
            if (vecs[v].sup) begin
                pulse(1'b0, 1'b1);
                run_xfer(1'b0, 0, vecs[v].nblk, 2, 1'b1);
                check("tbl_done_count", 32'(done_cnt - d0), 32'd1);
                check("tbl_save_no_wren", 32'(wren_cnt - w0), 32'd0);
            end else begin
                bad = 0;
                pulse(1'b1, 1'b0);
                pulse(1'b0, 1'b1);
                for (int i = 0; i < 6; i++) begin
                    if (sd_rd || sd_wr || busy || done) bad++;
                    tick();
                end
                check("unsup_idle", 32'(bad), 32'd0);
            end
        end

        // Full save: 0x03 / 8 KB, 16 blocks of 256 words.
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        d0 = done_cnt;
        w0 = wren_cnt;
        pulse(1'b0, 1'b1);
        run_xfer(1'b0, 0, 16, 256, 1'b1);
        check("save_done_count", 32'(done_cnt - d0), 32'd1);
        check("save_no_wren", 32'(wren_cnt - w0), 32'd0);

        // Full load: 0x1B / 32 KB, 64 blocks, word = {blk, addr}.
        cart_mbc_type = 8'h1B;
        cart_ram_size = 8'h03;
        w0 = wren_cnt;
        b0 = wren_bad;
        pulse(1'b1, 1'b0);
        run_xfer(1'b1, 0, 64, 256, 1'b1);
        tick();
        check("load_wren_count", 32'(wren_cnt - w0), 32'd16384);
        check("load_addr_eq_din", 32'(wren_bad - b0), 32'd0);
        check("load_busy_low", 32'(busy), 32'd0);

        // Simultaneous pulses pick load; a save pulse during XFER is ignored.
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h01;
        d0 = done_cnt;
        c0 = wr_cyc;
        pulse(1'b1, 1'b1);
        wait_req(1'b1, ok);
        check("both_load_req", 32'(ok), 32'd1);
        check("both_lba0", sd_lba, 32'd0);
        sd_ack = 1'b1;
        tick();
        pulse(1'b0, 1'b1);
        for (int a = 0; a < 2; a++) begin
            sd_buff_addr = 8'(a);
            sd_buff_dout = {8'h00, 8'(a)};
            sd_buff_wr   = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        run_xfer(1'b1, 1, 4, 2, 1'b1);
        repeat (4) tick();
        check("both_done_count", 32'(done_cnt - d0), 32'd1);
        check("both_no_sd_wr", 32'(wr_cyc - c0), 32'd0);
        check("both_idle_after", 32'(busy), 32'd0);

        // Reset in the middle of block 5 of a load.
        cart_mbc_type = 8'h03;
        cart_ram_size = 8'h02;
        pulse(1'b1, 1'b0);
        run_xfer(1'b1, 0, 5, 2, 1'b0);
        wait_req(1'b1, ok);
        check("rst_blk5_req", 32'(ok), 32'd1);
        check("rst_blk5_lba", sd_lba, 32'd5);
        sd_ack = 1'b1;
        tick();
        sd_buff_addr = 8'd0;
        sd_buff_dout = 16'h0500;
        sd_buff_wr   = 1'b1;
        tick();
        sd_buff_addr = 8'd1;
        sd_buff_dout = 16'h0501;
        reset        = 1'b1;
        tick();
        check("midrst_sd_rd", 32'(sd_rd), 32'd0);
        check("midrst_sd_wr", 32'(sd_wr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ram_wren", 32'(ram_wren), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset      = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        tick();
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
        run_xfer(1'b1, 0, 16, 2, 1'b1);
        check("restart_done_count", 32'(done_cnt - d0), 32'd1);

        // sd_ack never arrives.
        d0 = done_cnt;
        pulse(1'b1, 1'b0);
`ifdef CART_SAV_TIMEOUT_EN
        repeat (TB_TIMEOUT / 2) tick();
        check("to_err_early", 32'(sav_err), 32'd0);
        check("to_rd_held", 32'(sd_rd), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < TB_TIMEOUT + 50 && !ok; i++) begin
            tick();
            if (sav_err === 1'b1) ok = 1'b1;
        end
        check("to_err_set", 32'(ok), 32'd1);
        check("to_busy_low", 32'(busy), 32'd0);
        check("to_rd_low", 32'(sd_rd), 32'd0);
        repeat (3) tick();
        check("to_err_sticky", 32'(sav_err), 32'd1);
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        pulse(1'b1, 1'b0);
        tick();
        check("to_err_cleared", 32'(sav_err), 32'd0);
`else
        repeat (100) tick();
        check("noack_rd_held", 32'(sd_rd), 32'd1);
        check("noack_busy", 32'(busy), 32'd1);
        check("noack_err", 32'(sav_err), 32'd0);
        check("noack_no_done", 32'(done_cnt - d0), 32'd0);
`endif
        reset = 1'b1;
        tick();
        check("final_rst_busy", 32'(busy), 32'd0);
        check("final_rst_err", 32'(sav_err), 32'd0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_sav_engine.md
Name: cart_sav_engine

Overview:
- Backup engine on the clk_sys side of the cartridge RAM.
- It is the initiator on the otherwise unused port B of the cart RAM. Port B is 16-bit wide: low byte from the low bank, high byte from the high bank, shared word address.
- It moves cartridge save RAM to and from the SD-card block interface in 512-byte blocks.
  - Load: SD → cart RAM. Used after a save image is mounted.
  - Save: cart RAM → SD. Used on user request.

Parameters:
- LBA_W, 8, width of the block counter. 256 blocks × 512 B covers 128 KB of cart RAM.
- ACK_TIMEOUT, 1048575, clk_sys cycles allowed waiting for sd_ack. Used only with the optional feature.

Ports:
- clk_sys, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- cart_mbc_type, in, 8, cartridge header byte 0x147.
- cart_ram_size, in, 8, cartridge header byte 0x149.
- sav_load, in, 1, single-cycle start pulse for a load.
- sav_save, in, 1, single-cycle start pulse for a save.
- sav_supported, out, 1, the cartridge has battery-backed RAM.
- busy, out, 1, a transfer is in progress.
- done, out, 1, single-cycle pulse when a transfer completes.
- sav_err, out, 1, sticky timeout flag.
- sd_lba, out, 32, block number, zero-extended from the block counter.
- sd_rd, out, 1, block read request.
- sd_wr, out, 1, block write request.
- sd_ack, in, 1, SD side owns the buffer while high.
- sd_buff_addr, in, 8, 16-bit word index within the block.
- sd_buff_dout, in, 16, load data from SD.
- sd_buff_wr, in, 1, sd_buff_dout is valid this cycle.
- sd_buff_din, out, 16, save data to SD.
- ram_addr, out, 16, port-B word address.
- ram_wren, out, 1, port-B write enable for both byte banks.
- ram_din, out, 16, port-B write data.
- ram_q, in, 16, port-B read data, valid 1 clk after ram_addr.

Behaviour:
- Decoding (combinational):
  - sav_supported = battery type AND (cart_ram_size != 0 OR MBC2).
  - Battery types: 03, 06, 09, 0D, 10, 13, 1B, 1E, 22, FF.
  - MBC2 types: 05, 06.
- Last block index `last`:
  - MBC2: 0 (512 × 4-bit).
  - ram_size 1 (2 KB): 3.
  - ram_size 2 (8 KB): 15.
  - ram_size 3 (32 KB): 63.
  - Otherwise: 255.
- State machine: IDLE, REQ, XFER, DONE.
  - Reset: state IDLE, blk 0, dir 0.
  - Reset values of outputs: sd_rd 0, sd_wr 0, ram_wren 0, done 0, busy 0, sav_err 0, ram_din 0.
  - Reset mid-transfer aborts immediately with those same values. The partially written SD block is not completed.
- IDLE:
  - If sav_supported and sav_load: dir = load, blk 0, go to REQ.
  - Else if sav_supported and sav_save: dir = save, blk 0, go to REQ.
  - If both pulses arrive in the same cycle, load wins.
  - Pulses are ignored when sav_supported = 0; no done pulse is generated.
- REQ:
  - sd_lba = blk.
  - sd_rd = 1 for load, sd_wr = 1 for save, asserted the cycle after entry.
  - When sd_ack = 1 is seen: drop sd_rd/sd_wr next cycle, go to XFER.
- XFER:
  - Stay while sd_ack = 1.
  - On sd_ack 1 → 0: if blk == last go to DONE, else blk += 1 and go to REQ.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- sav_load / sav_save pulses while busy are ignored.
- Load datapath:
  - When sd_ack & sd_buff_wr: register ram_addr = {blk, sd_buff_addr} and ram_din = sd_buff_dout.
  - ram_wren = 1 on the next cycle only, for one cycle per word.
  - Back-to-back sd_buff_wr on consecutive cycles must each produce a write.
- Save datapath:
  - ram_addr = {blk, sd_buff_addr}, combinational while dir = save.
  - sd_buff_din = ram_q, so it is valid 1 clk after sd_buff_addr changes.
  - ram_wren stays 0 for the whole save.
- Outside transfers: ram_addr holds its last value and ram_wren = 0.
- No arithmetic overflow: blk never increments past last.

Optional Feature:
- Macro: CART_SAV_TIMEOUT_EN.
- When defined:
  - A 20-bit counter clears on entry to REQ and increments each cycle in REQ.
  - If it reaches ACK_TIMEOUT before sd_ack is seen: sav_err = 1 (sticky until reset or the next accepted start), sd_rd/sd_wr drop, state goes to IDLE without a done pulse.
- When undefined: REQ waits indefinitely and sav_err is tied 0.

Test Plan:
- Type 0x03, ram_size 2, sav_save pulse:
  - 16 sd_wr requests with sd_lba 0..15.
  - Each block returns sd_buff_din = ram_q for word addresses {blk, 0..255}.
  - done pulses once after the 16th sd_ack fall.
- Type 0x1B, ram_size 3, sav_load:
  - SD model streams pattern word = {blk, addr}.
  - Exactly 64 × 256 ram_wren pulses, each with ram_addr == ram_din.
  - busy low after done.
- Type 0x06 (MBC2), ram_size 0:
  - sav_supported = 1, sav_save produces a single block with sd_lba 0.
- Type 0x01, ram_size 2 (no battery):
  - sav_supported = 0; sav_load and sav_save produce no sd_rd/sd_wr, busy 0, done 0.
- sav_save and sav_load in the same cycle, then sav_save again during XFER:
  - Load runs; the second pulse is ignored.
- Reset asserted during XFER of block 5:
  - Next cycle sd_rd/sd_wr 0, busy 0, ram_wren 0.
  - A new sav_load restarts at sd_lba 0.
  - With CART_SAV_TIMEOUT_EN and sd_ack never asserted, sav_err = 1 after ACK_TIMEOUT cycles.
